// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: word width, reset/NOP constants,
// IF/ID occupancy states and instruction field extractors.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int IMM16_W  = 16;
    localparam int JIDX26_W = 26;

    // IF/ID occupancy; the encoding doubles as the ifid_valid output bit.
    typedef enum logic {
        IFID_EMPTY = 1'b0,
        IFID_FULL  = 1'b1
    } ifid_state_t;

    function automatic logic [IMM16_W-1:0] imm16(input logic [WORD_W-1:0] instr);
        return instr[IMM16_W-1:0];
    endfunction

    function automatic logic [JIDX26_W-1:0] jidx26(input logic [WORD_W-1:0] instr);
        return instr[JIDX26_W-1:0];
    endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection: sequential PC+4 or an ID-resolved redirect
// (jr > jump > branch), only honoured while IF/ID holds a real instruction.
module mips_next_pc
    import mips_pkg::*;
(
    input  logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] ifid_instr,
    input  logic [WORD_W-1:0] ifid_pc_plus4,
    input  logic              ifid_valid,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              jr,
    input  logic [WORD_W-1:0] jr_target,
    output logic [WORD_W-1:0] next_pc,
    output logic              redirect
);

    logic [IMM16_W-1:0]  imm;
    logic [JIDX26_W-1:0] jidx;
    logic [WORD_W-1:0]   branch_offset;

    assign imm  = imm16(ifid_instr);
    assign jidx = jidx26(ifid_instr);

    // Word-aligned, sign-extended branch displacement.
    assign branch_offset[1:0] = 2'b00;
    generate
        for (genvar gi = 0; gi < IMM16_W; gi++) begin : g_off_lo
            assign branch_offset[gi+2] = imm[gi];
        end
        for (genvar gi = IMM16_W + 2; gi < WORD_W; gi++) begin : g_off_sx
            assign branch_offset[gi] = imm[IMM16_W-1];
        end
    endgenerate

    always_comb begin
        redirect = ifid_valid & (jr | jump | branch_taken);
        next_pc  = pc + 32'd4;
        if (redirect) begin
            if (jr) begin
                next_pc = {jr_target[WORD_W-1:2], 2'b00};
            end else if (jump) begin
                next_pc = {ifid_pc_plus4[WORD_W-1:28], jidx, 2'b00};
            end else begin
                next_pc = ifid_pc_plus4 + branch_offset;
            end
        end
    end

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, the IF/ID pipeline register and the
// fetch counter; redirects flush the wrong-path word and leave one bubble.
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC  = mips_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        redirect,
    output logic [31:0] fetch_count
);
    import mips_pkg::*;

    logic [WORD_W-1:0] pc_reg,            pc_next;
    logic [WORD_W-1:0] ifid_instr_reg,    ifid_instr_next;
    logic [WORD_W-1:0] ifid_pc_plus4_reg, ifid_pc_plus4_next;
    logic [WORD_W-1:0] fetch_count_reg,   fetch_count_next;
    ifid_state_t       state_reg,         state_next;
    logic [WORD_W-1:0] target_pc;

    mips_next_pc u_next_pc (
        .pc            (pc_reg),
        .ifid_instr    (ifid_instr_reg),
        .ifid_pc_plus4 (ifid_pc_plus4_reg),
        .ifid_valid    (ifid_valid),
        .branch_taken  (branch_taken),
        .jump          (jump),
        .jr            (jr),
        .jr_target     (jr_target),
        .next_pc       (target_pc),
        .redirect      (redirect)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg            <= RESET_PC;
            ifid_instr_reg    <= NOP_INSTR;
            ifid_pc_plus4_reg <= '0;
            fetch_count_reg   <= '0;
            state_reg         <= IFID_EMPTY;
        end else begin
            pc_reg            <= pc_next;
            ifid_instr_reg    <= ifid_instr_next;
            ifid_pc_plus4_reg <= ifid_pc_plus4_next;
            fetch_count_reg   <= fetch_count_next;
            state_reg         <= state_next;
        end
    end

    // Redirect beats stall: the wrong-path word must never survive a hold.
    always_comb begin
        pc_next            = pc_reg;
        ifid_instr_next    = ifid_instr_reg;
        ifid_pc_plus4_next = ifid_pc_plus4_reg;
        fetch_count_next   = fetch_count_reg;
        state_next         = state_reg;
        if (redirect) begin
            pc_next            = target_pc;
            ifid_instr_next    = NOP_INSTR;
            ifid_pc_plus4_next = '0;
            state_next         = IFID_EMPTY;
        end else if (!stall) begin
            pc_next            = target_pc;
            ifid_instr_next    = imem_instr;
            ifid_pc_plus4_next = pc_reg + 32'd4;
            fetch_count_next   = fetch_count_reg + 32'd1;
            state_next         = IFID_FULL;
        end
    end

    assign imem_addr     = pc_reg;
    assign ifid_instr    = ifid_instr_reg;
    assign ifid_pc_plus4 = ifid_pc_plus4_reg;
    assign ifid_valid    = (state_reg == IFID_FULL);
    assign fetch_count   = fetch_count_reg;

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
Instruction-fetch stage of the MIPS pipeline, directly upstream of the instruction memory. It drives the PC into the combinational instruction memory and captures the returned word into the IF/ID pipeline register. It handles stall, taken-branch, jump and jr redirects resolved in ID, flushing the wrong-path instruction. There is no branch delay slot.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on flush (sll $0,$0,0).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
imem_addr  out  32  current PC, to instruction memory address.
imem_instr  in  32  instruction word returned combinationally for imem_addr.
stall  in  1  hazard unit: hold PC and IF/ID.
branch_taken  in  1  ID: branch in IF/ID resolved taken.
jump  in  1  ID: IF/ID holds j/jal.
jr  in  1  ID: IF/ID holds jr/jalr.
jr_target  in  32  register value for jr.
ifid_instr  out  32  IF/ID instruction.
ifid_pc_plus4  out  32  IF/ID PC+4 of that instruction.
ifid_valid  out  1  IF/ID holds a real instruction.
redirect  out  1  combinational: a redirect is taken this cycle.
fetch_count  out  32  instructions latched into IF/ID since reset.

Behaviour:
- Reset, sampled at posedge: PC=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus4=0, ifid_valid=0, fetch_count=0. Reset overrides all other inputs, including mid-stall or mid-redirect.
- imem_addr = PC at all times, with zero combinational dependence on the inputs.
- Two states, encoded by ifid_valid: EMPTY (0) and FULL (1). Redirect inputs are ignored in EMPTY, and redirect is 0 in EMPTY.
- redirect = ifid_valid & (jr | jump | branch_taken).
- Target priority: jr > jump > branch.
  - jr target = {jr_target[31:2], 2'b00}. The low bits are forced to zero.
  - jump target = {ifid_pc_plus4[31:28], ifid_instr[25:0], 2'b00}.
  - branch target = ifid_pc_plus4 + {sext(ifid_instr[15:0]), 2'b00}, modulo 2^32.
- Per-cycle priority when not in reset:
  1. redirect: PC <= target; IF/ID <= NOP_INSTR, pc_plus4 0, valid 0 (goes to EMPTY). Redirect overrides stall. fetch_count unchanged.
  2. stall: PC, IF/ID and fetch_count hold.
  3. otherwise: PC <= PC+4 (wraps 0xFFFFFFFC -> 0); IF/ID <= imem_instr, PC+4, valid 1; fetch_count += 1 (wraps).
- Latency: an instruction at address A appears in IF/ID one edge after imem_addr = A without stall. The first valid IF/ID appears one edge after reset deasserts.
- The redirect target is fetched in the cycle after redirect. Its instruction reaches IF/ID one edge later (one bubble).

Decomposition:
- Shared package mips_pkg: NOP_INSTR, default RESET_PC, WORD_W=32, instruction field slices (IMM16, JIDX26).
- One combinational sub-module, mips_next_pc: inputs PC, IF/ID contents, redirect controls and jr_target; outputs next_pc and redirect.
- The top level holds the PC, IF/ID and fetch_count registers.

Test Plan:
1. Reset with RESET_PC=0, mem[0]=0x2008_0005, no stalls. After the first edge post-reset: imem_addr=4, ifid_instr=0x2008_0005, ifid_pc_plus4=4, ifid_valid=1, fetch_count=1.
2. Branch: IF/ID holds imm 0x0003 with pc_plus4=4, branch_taken=1. Next edge: PC=0x10, ifid_valid=0, ifid_instr=0. With imm 0xFFFF and pc_plus4=8, the target is 4.
3. Jump: ifid_instr=0x0800_0010, pc_plus4=8, jump=1. Next PC=0x40. With jr=1 asserted at the same time and jr_target=0x103, PC=0x100 (jr wins, low bits cleared).
4. Stall: stall=1 for 3 cycles at PC=8. PC stays 8; IF/ID and fetch_count are unchanged. On release, PC=0xC. With stall=1 and branch_taken=1 together, the redirect wins.
5. Boundaries:
   - RESET_PC=0xFFFF_FFFC: one edge gives PC=0, ifid_pc_plus4=0.
   - branch_taken=1 while ifid_valid=0: ignored, redirect=0, PC+4.
6. Reset asserted mid-stall and mid-redirect: next edge PC=RESET_PC, ifid_valid=0, fetch_count=0.
